// File: rtl/pwm_timer_pkg.sv
// Shared register map and CTRL bit positions for the PWM timer.
package pwm_timer_pkg;

   localparam logic [7:0] OffCtrl   = 8'h00;
   localparam logic [7:0] OffPeriod = 8'h04;
   localparam logic [7:0] OffDuty0  = 8'h08;
   localparam logic [7:0] OffCount  = 8'h20;
   localparam logic [7:0] OffStatus = 8'h24;

   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlIeBit   = 1;
   localparam int unsigned CtrlPolBase = 2;

   function automatic logic [7:0] duty_offset(input int unsigned ch);
      return OffDuty0 + 8'(4 * ch);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register, compare against the shared counter,
// polarity inversion and the registered output.
module pwm_channel #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic             pol,
   input  logic [CNT_W-1:0] duty_stage,
   input  logic [CNT_W-1:0] count,
   output logic             pwm
);

   logic [CNT_W-1:0] duty_sh_q;
   logic             pwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_sh_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         if (load) duty_sh_q <= duty_stage;
         pwm_q <= en ? ((count < duty_sh_q) ^ pol) : pol;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/pwm_timer.sv
// Multi-channel PWM timer with shadowed period/duty registers, a shared
// free-running counter and a level period-wrap interrupt on a rib slave port.
module pwm_timer
   import pwm_timer_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              int_sig_o
);

   localparam int unsigned CW = NUM_CH + 2;

   logic [CW-1:0]    ctrl_q;
   logic [CNT_W-1:0] period_q, period_sh_q, count_q, count_d;
   logic [CNT_W-1:0] duty_q [NUM_CH];
   logic             status_q, status_d;
   logic [7:0]       reg_addr;
   logic             en, en_nxt, wrap, load_sh, ctrl_wr, status_clr;
   logic             unused_bits;

   assign reg_addr    = addr_i[7:0];
   assign unused_bits = ^{addr_i[31:8], data_i};

   assign en         = ctrl_q[CtrlEnBit];
   assign ctrl_wr    = we_i && (reg_addr == OffCtrl);
   assign en_nxt     = ctrl_wr ? data_i[CtrlEnBit] : en;
   assign wrap       = en && (count_q == period_sh_q);
   assign load_sh    = wrap || !en;
   assign status_clr = we_i && (reg_addr == OffStatus) && data_i[0];

   // Clearing en zeroes the counter at the same edge the write lands.
   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (!en || !en_nxt || wrap) count_d = '0;
   end

   always_comb begin
      status_d = status_q;
      if (status_clr) status_d = 1'b0;
      if (wrap)       status_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q      <= '0;
         period_q    <= '0;
         period_sh_q <= '0;
         count_q     <= '0;
         status_q    <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
      end else begin
         if (ctrl_wr) ctrl_q <= data_i[CW-1:0];
         if (we_i && (reg_addr == OffPeriod)) period_q <= data_i[CNT_W-1:0];
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (we_i && (reg_addr == duty_offset(i))) duty_q[i] <= data_i[CNT_W-1:0];
         end
         if (load_sh) period_sh_q <= period_q;
         count_q  <= count_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      data_o = '0;
      case (reg_addr)
         OffCtrl:   data_o = 32'(ctrl_q);
         OffPeriod: data_o = 32'(period_q);
         OffCount:  data_o = 32'(count_q);
         OffStatus: data_o = {31'b0, status_q};
         default:   ;
      endcase
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (reg_addr == duty_offset(i)) data_o = 32'(duty_q[i]);
      end
   end

   assign int_sig_o = status_q && ctrl_q[CtrlIeBit];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .load      (load_sh),
         .en        (en),
         .pol       (ctrl_q[CtrlPolBase+g]),
         .duty_stage(duty_q[g]),
         .count     (count_q),
         .pwm       (pwm_o[g])
      );
   end

endmodule

// File: tb/tb_pwm_timer.sv
// Directed bench for pwm_timer: expected values are queued as stimulus is
// driven and popped when the DUT output is sampled.
module tb_pwm_timer;

   logic        clk = 1'b0;
   logic        rst, we_i;
   logic [31:0] addr_i, data_i, data_o;
   logic [1:0]  pwm_o;
   logic        int_sig_o;

   int          n_err = 0;
   int          n_checks = 0;
   logic [31:0] exp_q[$];

   pwm_timer #(
      .NUM_CH(2),
      .CNT_W (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .data_o   (data_o),
      .pwm_o    (pwm_o),
      .int_sig_o(int_sig_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      tick();
      we_i   = 1'b0;
      addr_i = '0;
      data_i = '0;
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
      push(e);
      addr_i = a;
      #1;
      chk(tag, data_o);
   endtask

   task automatic chk_pins(input string tag, input logic [1:0] e_pwm, input logic e_int);
      push(32'(e_pwm));
      chk({tag, "_pwm"}, 32'(pwm_o));
      push(32'(e_int));
      chk({tag, "_int"}, 32'(int_sig_o));
   endtask

   initial begin
      rst    = 1'b1;
      we_i   = 1'b0;
      addr_i = '0;
      data_i = '0;
      tick();
      tick();
      chk_pins("reset", 2'b00, 1'b0);
      chk_rd("reset_ctrl", 32'h00, 32'h0);
      chk_rd("reset_count", 32'h20, 32'h0);
      rst = 1'b0;

      // Bus basics while disabled
      chk_rd("unmapped_rd", 32'h30, 32'h0);
      wr(32'h04, 32'hFFFF_1234);
      chk_rd("period_trunc", 32'h04, 32'h0000_1234);
      wr(32'h0C, 32'h1234_ABCD);
      chk_rd("duty1_trunc", 32'h0C, 32'h0000_ABCD);
      wr(32'h20, 32'h55);
      chk_rd("count_ro_idle", 32'h20, 32'h0);

      // Basic PWM: period 9, duty 3
      wr(32'h04, 32'd9);
      wr(32'h08, 32'd3);
      wr(32'h00, 32'h1);
      chk_pins("en_edge", 2'b00, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         push(32'(((k - 1) % 10) < 3));
         tick();
         chk("basic_pwm0", 32'(pwm_o[0]));
      end
      wr(32'h20, 32'h55);
      chk_rd("count_ro_run", 32'h20, 32'd1);

      // Shadowed duty update mid-period
      wr(32'h00, 32'h0);
      wr(32'h00, 32'h1);
      for (int k = 1; k <= 4; k++) tick();
      wr(32'h08, 32'd7);
      for (int k = 6; k <= 25; k++) begin
         push(32'(((k - 1) % 10) < ((k <= 10) ? 3 : 7)));
         tick();
         chk("shadow_pwm0", 32'(pwm_o[0]));
      end

      // Edge duties and polarity
      wr(32'h00, 32'h0);
      wr(32'h08, 32'd0);
      wr(32'h0C, 32'd12);
      wr(32'h00, 32'h1);
      tick();
      for (int k = 0; k < 12; k++) begin
         push(32'b10);
         tick();
         chk("edge_duty", 32'(pwm_o));
      end
      wr(32'h00, 32'h5);
      tick();
      for (int k = 0; k < 12; k++) begin
         push(32'b11);
         tick();
         chk("edge_pol0", 32'(pwm_o));
      end

      // Interrupt and W1C behaviour
      wr(32'h00, 32'h0);
      wr(32'h24, 32'h1);
      wr(32'h04, 32'd4);
      wr(32'h00, 32'h3);
      chk_rd("irq_status0", 32'h24, 32'h0);
      push(32'h0);
      chk("irq_int0", 32'(int_sig_o));
      for (int k = 0; k < 4; k++) tick();
      push(32'h0);
      chk("irq_before_wrap", 32'(int_sig_o));
      tick();
      push(32'h1);
      chk("irq_after_wrap", 32'(int_sig_o));
      chk_rd("irq_status1", 32'h24, 32'h1);
      for (int k = 0; k < 4; k++) tick();
      wr(32'h24, 32'h1);
      chk_rd("w1c_on_wrap", 32'h24, 32'h1);
      push(32'h1);
      chk("w1c_on_wrap_int", 32'(int_sig_o));
      wr(32'h24, 32'h1);
      chk_rd("w1c_clear", 32'h24, 32'h0);
      push(32'h0);
      chk("w1c_clear_int", 32'(int_sig_o));

      // Disable mid-period, then reset with a concurrent write
      wr(32'h00, 32'h0);
      wr(32'h08, 32'd8);
      wr(32'h0C, 32'd0);
      wr(32'h04, 32'd9);
      wr(32'h00, 32'h1);
      for (int k = 0; k < 5; k++) tick();
      chk_rd("dis_count5", 32'h20, 32'd5);
      push(32'b01);
      chk("dis_pwm_run", 32'(pwm_o));
      wr(32'h00, 32'h8);
      chk_rd("dis_count0", 32'h20, 32'd0);
      tick();
      push(32'b10);
      chk("dis_pwm_pol", 32'(pwm_o));

      rst    = 1'b1;
      we_i   = 1'b1;
      addr_i = 32'h04;
      data_i = 32'd7;
      tick();
      rst  = 1'b0;
      we_i = 1'b0;
      chk_rd("rst_ctrl", 32'h00, 32'h0);
      chk_rd("rst_period", 32'h04, 32'h0);
      chk_rd("rst_duty0", 32'h08, 32'h0);
      chk_rd("rst_duty1", 32'h0C, 32'h0);
      chk_rd("rst_status", 32'h24, 32'h0);
      chk_pins("rst_pins", 2'b00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
